// File: rtl/line_buf_pp.sv
// Double-banked line buffer: display reads (clear-on-read) from the front bank,
// sprite writes with priority/collision detection into the back bank.
module line_buf_pp #(
  parameter int            AW    = 9,
  parameter int            DW    = 11,
  parameter logic [DW-1:0] TRANS = '0,
  parameter bit            PRIO  = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          swap,
  input  logic          re,
  input  logic [AW-1:0] radr,
  output logic [DW-1:0] rdat,
  output logic          rvalid,
  input  logic          we,
  input  logic [AW-1:0] wadr,
  input  logic [DW-1:0] wdat,
  output logic          coll,
  output logic          bank,
  output logic          ready
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {INIT, RUN} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] init_cnt;
  logic [DW-1:0] mem [2][DEPTH];

  logic          rd_acc, wr_acc, sw_acc;
  logic          wr_bank;

  // Commit stage of the sprite read-modify-write
  logic          p_v;
  logic [AW-1:0] p_adr;
  logic [DW-1:0] p_dat;
  logic [DW-1:0] p_old;
  logic          p_bank;

  logic          commit, blocked;
  logic [DW-1:0] rd_src, old_src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    case (state)
      INIT: if (init_cnt == {AW{1'b1}}) state_nx = RUN;
      RUN:  ready = 1'b1;
      default: state_nx = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              init_cnt <= '0;
    else if (state == INIT)  init_cnt <= init_cnt + 1'b1;
  end

  assign rd_acc  = ready & re;
  assign wr_acc  = ready & we;
  assign sw_acc  = ready & swap;
  assign wr_bank = ~bank;

  assign commit  = p_v && (p_dat != TRANS) && (!PRIO || (p_old == TRANS));
  assign blocked = p_v && (p_dat != TRANS) && PRIO && (p_old != TRANS);

  // A commit landing this edge on the location being read is forwarded, so a
  // write accepted earlier is seen exactly as if the operations were serial.
  always_comb begin
    rd_src  = mem[bank][radr];
    old_src = mem[wr_bank][wadr];
    if (commit && (p_bank == bank) && (p_adr == radr))
      rd_src = p_dat;
    if (commit && (p_bank == wr_bank) && (p_adr == wadr))
      old_src = p_dat;
  end

  // Clear-on-read is issued after the commit so it wins on a shared address.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[0][init_cnt] <= TRANS;
      mem[1][init_cnt] <= TRANS;
    end else begin
      if (commit) mem[p_bank][p_adr] <= p_dat;
      if (rd_acc) mem[bank][radr]    <= TRANS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_v    <= 1'b0;
      p_adr  <= '0;
      p_dat  <= '0;
      p_old  <= '0;
      p_bank <= 1'b0;
    end else begin
      p_v <= wr_acc;
      if (wr_acc) begin
        p_adr  <= wadr;
        p_dat  <= wdat;
        p_old  <= old_src;
        p_bank <= wr_bank;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdat   <= '0;
      rvalid <= 1'b0;
      bank   <= 1'b0;
      coll   <= 1'b0;
    end else begin
      rvalid <= rd_acc;
      if (rd_acc) rdat <= rd_src;
      if (sw_acc) bank <= ~bank;
      coll <= (coll & ~sw_acc) | blocked;
    end
  end

endmodule
